// File: rtl/reg_file_sb.sv
// reg_file_sb: XLEN x 2**AW integer register file with write-back forwarding
// and a per-register busy scoreboard for RAW hazard detection at decode.
// Ports:
//   clk_in, rst_in (async, active-high)
//   rs1/rs2_addr_in -> rs1/rs2_out, rs1/rs2_busy_out (combinational reads)
//   issue_en_in/issue_rd_in (scoreboard set)
//   wr_en_in/wr_addr_in/wr_data_in (write-back)
//   flush_in (clears busy bits)
//   busy_cnt_out (registered popcount of busy bits)
module reg_file_sb #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic [AW-1:0]   rs1_addr_in,
  input  logic [AW-1:0]   rs2_addr_in,
  output logic [XLEN-1:0] rs1_out,
  output logic [XLEN-1:0] rs2_out,
  output logic            rs1_busy_out,
  output logic            rs2_busy_out,
  input  logic            issue_en_in,
  input  logic [AW-1:0]   issue_rd_in,
  input  logic            wr_en_in,
  input  logic [AW-1:0]   wr_addr_in,
  input  logic [XLEN-1:0] wr_data_in,
  input  logic            flush_in,
  output logic [AW:0]     busy_cnt_out
);

  localparam int NREGS = 1 << AW;

  logic [XLEN-1:0]  mem [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic [AW:0]      cnt_nxt;
  logic             iss_v;
  logic             wb_v;
  logic             inc;
  logic             dec;
  logic             fwd1;
  logic             fwd2;

  // x0 is invisible to both the array and the scoreboard
  assign iss_v = issue_en_in && (issue_rd_in != '0);
  assign wb_v  = wr_en_in && (wr_addr_in != '0);

  // Issue beats flush beats write-back: the newest producer owns the reg
  always_comb begin
    busy_nxt = busy;
    for (int r = 1; r < NREGS; r++) begin
      if (iss_v && (issue_rd_in == AW'(r)))
        busy_nxt[r] = 1'b1;
      else if (flush_in)
        busy_nxt[r] = 1'b0;
      else if (wb_v && (wr_addr_in == AW'(r)))
        busy_nxt[r] = 1'b0;
    end
    busy_nxt[0] = 1'b0;
  end

  // Incremental popcount: only transitions of a bit move the count
  assign inc = iss_v && !busy[issue_rd_in];
  assign dec = wb_v && busy[wr_addr_in]
            && !(iss_v && (issue_rd_in == wr_addr_in));

  always_comb begin
    cnt_nxt = busy_cnt_out;
    if (flush_in)
      cnt_nxt = {{AW{1'b0}}, iss_v};
    else
      cnt_nxt = busy_cnt_out
              + {{AW{1'b0}}, inc}
              - {{AW{1'b0}}, dec};
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy         <= '0;
      busy_cnt_out <= '0;
    end else begin
      busy         <= busy_nxt;
      busy_cnt_out <= cnt_nxt;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int r = 0; r < NREGS; r++)
        mem[r] <= '0;
    end else if (wb_v) begin
      mem[wr_addr_in] <= wr_data_in;
    end
  end

  assign fwd1 = BYPASS && wb_v && (wr_addr_in == rs1_addr_in);
  assign fwd2 = BYPASS && wb_v && (wr_addr_in == rs2_addr_in);

  always_comb begin
    rs1_out = '0;
    if (rs1_addr_in == '0)
      rs1_out = '0;
    else if (fwd1)
      rs1_out = wr_data_in;
    else
      rs1_out = mem[rs1_addr_in];
  end

  always_comb begin
    rs2_out = '0;
    if (rs2_addr_in == '0)
      rs2_out = '0;
    else if (fwd2)
      rs2_out = wr_data_in;
    else
      rs2_out = mem[rs2_addr_in];
  end

  // Forwarded data satisfies the hazard, so busy drops in that cycle
  assign rs1_busy_out = (rs1_addr_in != '0)
                     && busy[rs1_addr_in] && !fwd1;
  assign rs2_busy_out = (rs2_addr_in != '0)
                     && busy[rs2_addr_in] && !fwd2;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: drives a bypassing and a non-bypassing reg_file_sb with
// shared stimulus and compares both against an array/popcount model.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        flush;

  logic [31:0] b_rs1, b_rs2, n_rs1, n_rs2;
  logic        b_bz1, b_bz2, n_bz1, n_bz2;
  logic [5:0]  b_cnt, n_cnt;

  int nvec = 0;
  int nerr = 0;

  logic [31:0] m_mem  [32];
  bit          m_busy [32];

  always #5 clk = ~clk;

  reg_file_sb #(.XLEN(32), .AW(5), .BYPASS(1'b1)) dut_b (
    .clk_in(clk), .rst_in(rst),
    .rs1_addr_in(rs1_addr), .rs2_addr_in(rs2_addr),
    .rs1_out(b_rs1), .rs2_out(b_rs2),
    .rs1_busy_out(b_bz1), .rs2_busy_out(b_bz2),
    .issue_en_in(issue_en), .issue_rd_in(issue_rd),
    .wr_en_in(wr_en), .wr_addr_in(wr_addr), .wr_data_in(wr_data),
    .flush_in(flush), .busy_cnt_out(b_cnt)
  );

  reg_file_sb #(.XLEN(32), .AW(5), .BYPASS(1'b0)) dut_n (
    .clk_in(clk), .rst_in(rst),
    .rs1_addr_in(rs1_addr), .rs2_addr_in(rs2_addr),
    .rs1_out(n_rs1), .rs2_out(n_rs2),
    .rs1_busy_out(n_bz1), .rs2_busy_out(n_bz2),
    .issue_en_in(issue_en), .issue_rd_in(issue_rd),
    .wr_en_in(wr_en), .wr_addr_in(wr_addr), .wr_data_in(wr_data),
    .flush_in(flush), .busy_cnt_out(n_cnt)
  );

  function automatic void m_clear();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endfunction

  function automatic int m_cnt();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 0) return '0;
    if (byp && wr_en && wr_addr == a) return wr_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_bz(input logic [4:0] a, input bit byp);
    if (a == 0) return 1'b0;
    if (byp && wr_en && wr_addr == a) return 1'b0;
    return m_busy[a];
  endfunction

  // One rising edge; model applies the architectural rules directly
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_clear();
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (issue_en && issue_rd == r) m_busy[r] = 1'b1;
        else if (flush) m_busy[r] = 1'b0;
        else if (wr_en && wr_addr == r) m_busy[r] = 1'b0;
      end
      if (wr_en && wr_addr != 0) m_mem[wr_addr] = wr_data;
    end
    #1;
  endtask

  task automatic idle();
    issue_en = 0; issue_rd = 0;
    wr_en = 0; wr_addr = 0; wr_data = 0;
    flush = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle(); rs1_addr = 0; rs2_addr = 0;
    m_clear();
    tick(); tick();
    rst = 0;
    for (int a = 0; a < 32; a++) begin
      rs1_addr = 5'(a); rs2_addr = 5'(31 - a);
      #1;
      nvec++;
      if ({b_rs1, b_rs2, n_rs1, n_rs2} !== '0) begin
        nerr++;
        $display("FAIL reset_rd a=%0d got %h %h %h %h want 0",
                 a, b_rs1, b_rs2, n_rs1, n_rs2);
      end
      nvec++;
      if ({b_bz1, b_bz2, n_bz1, n_bz2} !== 4'b0) begin
        nerr++;
        $display("FAIL reset_busy a=%0d got %b%b%b%b want 0000",
                 a, b_bz1, b_bz2, n_bz1, n_bz2);
      end
    end
    nvec++;
    if (b_cnt !== 6'd0 || n_cnt !== 6'd0) begin
      nerr++;
      $display("FAIL reset_cnt got %0d/%0d want 0", b_cnt, n_cnt);
    end
    tick();
  endtask

  task automatic test_bypass();
    wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
    rs1_addr = 5; rs2_addr = 0;
    #1;
    nvec++;
    if (b_rs1 !== 32'hDEADBEEF) begin
      nerr++;
      $display("FAIL bypass_same got %h want deadbeef", b_rs1);
    end
    nvec++;
    if (n_rs1 !== 32'h0) begin
      nerr++;
      $display("FAIL nobypass_same got %h want 0", n_rs1);
    end
    tick();
    idle();
    #1;
    nvec++;
    if (b_rs1 !== 32'hDEADBEEF || n_rs1 !== 32'hDEADBEEF) begin
      nerr++;
      $display("FAIL write_after got %h/%h want deadbeef", b_rs1, n_rs1);
    end
  endtask

  task automatic test_x0();
    int c0;
    c0 = m_cnt();
    wr_en = 1; wr_addr = 0; wr_data = 32'h12345678;
    issue_en = 1; issue_rd = 0;
    rs1_addr = 0; rs2_addr = 0;
    #1;
    nvec++;
    if (b_rs1 !== 32'h0 || n_rs1 !== 32'h0) begin
      nerr++;
      $display("FAIL x0_same got %h/%h want 0", b_rs1, n_rs1);
    end
    tick();
    idle();
    #1;
    nvec++;
    if (b_rs1 !== 32'h0 || n_rs1 !== 32'h0 || b_bz1 !== 1'b0) begin
      nerr++;
      $display("FAIL x0_after got %h/%h bz %b want 0", b_rs1, n_rs1, b_bz1);
    end
    nvec++;
    if (int'(b_cnt) != c0 || int'(n_cnt) != c0) begin
      nerr++;
      $display("FAIL x0_cnt got %0d/%0d want %0d", b_cnt, n_cnt, c0);
    end
  endtask

  task automatic test_scoreboard();
    issue_en = 1; issue_rd = 3; tick();
    issue_rd = 7; tick();
    idle(); rs1_addr = 3; rs2_addr = 7;
    #1;
    nvec++;
    if (b_cnt !== 6'd2 || n_cnt !== 6'd2) begin
      nerr++;
      $display("FAIL sb_cnt2 got %0d/%0d want 2", b_cnt, n_cnt);
    end
    nvec++;
    if ({b_bz1, b_bz2, n_bz1, n_bz2} !== 4'b1111) begin
      nerr++;
      $display("FAIL sb_busy got %b%b%b%b want 1111",
               b_bz1, b_bz2, n_bz1, n_bz2);
    end
    wr_en = 1; wr_addr = 3; wr_data = 32'h11;
    #1;
    nvec++;
    if (b_bz1 !== 1'b0 || n_bz1 !== 1'b1) begin
      nerr++;
      $display("FAIL sb_wb_same got b=%b n=%b want b=0 n=1", b_bz1, n_bz1);
    end
    tick();
    idle();
    #1;
    nvec++;
    if (b_cnt !== 6'd1 || n_cnt !== 6'd1 || n_bz1 !== 1'b0) begin
      nerr++;
      $display("FAIL sb_wb_after got cnt %0d/%0d nbz %b want 1/1/0",
               b_cnt, n_cnt, n_bz1);
    end
  endtask

  task automatic test_waw();
    issue_en = 1; issue_rd = 9; tick();
    rs1_addr = 9;
    wr_en = 1; wr_addr = 9; wr_data = 32'h22;
    #1;
    nvec++;
    if (b_rs1 !== 32'h22 || b_bz1 !== 1'b0 || n_bz1 !== 1'b1) begin
      nerr++;
      $display("FAIL waw_same got %h bz %b/%b want 22 0/1",
               b_rs1, b_bz1, n_bz1);
    end
    tick();
    idle();
    #1;
    nvec++;
    if (b_bz1 !== 1'b1 || n_bz1 !== 1'b1 || n_rs1 !== 32'h22) begin
      nerr++;
      $display("FAIL waw_after got bz %b/%b data %h want 1/1 22",
               b_bz1, n_bz1, n_rs1);
    end
    nvec++;
    if (b_cnt !== 6'd2 || n_cnt !== 6'd2) begin
      nerr++;
      $display("FAIL waw_cnt got %0d/%0d want 2", b_cnt, n_cnt);
    end
  endtask

  task automatic test_flush();
    issue_en = 1; issue_rd = 11; tick();
    issue_rd = 12; tick();
    idle();
    #1;
    nvec++;
    if (b_cnt !== 6'd4) begin
      nerr++;
      $display("FAIL flush_pre got %0d want 4", b_cnt);
    end
    flush = 1; issue_en = 1; issue_rd = 10;
    tick();
    idle();
    #1;
    nvec++;
    if (b_cnt !== 6'd1 || n_cnt !== 6'd1) begin
      nerr++;
      $display("FAIL flush_cnt got %0d/%0d want 1", b_cnt, n_cnt);
    end
    for (int a = 0; a < 32; a++) begin
      rs1_addr = 5'(a);
      #1;
      nvec++;
      if (n_bz1 !== (a == 10)) begin
        nerr++;
        $display("FAIL flush_busy a=%0d got %b want %b", a, n_bz1, a == 10);
      end
    end
    rs1_addr = 5; rs2_addr = 10;
    @(negedge clk);
    #1;
    rst = 1;
    m_clear();
    #1;
    nvec++;
    if (b_rs1 !== 32'h0 || n_rs1 !== 32'h0 || b_cnt !== 6'd0
        || n_bz2 !== 1'b0) begin
      nerr++;
      $display("FAIL async_rst got %h/%h cnt %0d bz %b want 0",
               b_rs1, n_rs1, b_cnt, n_bz2);
    end
    tick();
    rst = 0;
    tick();
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      issue_en = ($urandom_range(0, 2) == 0);
      issue_rd = rnd_addr();
      wr_en    = ($urandom_range(0, 1) == 0);
      wr_addr  = rnd_addr();
      wr_data  = $urandom;
      flush    = ($urandom_range(0, 29) == 0);
      rs1_addr = rnd_addr();
      rs2_addr = rnd_addr();
      #1;
      nvec++;
      if (b_rs1 !== exp_rd(rs1_addr, 1) || b_rs2 !== exp_rd(rs2_addr, 1)) begin
        nerr++;
        $display("FAIL rnd_b_rd i=%0d got %h %h want %h %h", i, b_rs1, b_rs2,
                 exp_rd(rs1_addr, 1), exp_rd(rs2_addr, 1));
      end
      nvec++;
      if (n_rs1 !== exp_rd(rs1_addr, 0) || n_rs2 !== exp_rd(rs2_addr, 0)) begin
        nerr++;
        $display("FAIL rnd_n_rd i=%0d got %h %h want %h %h", i, n_rs1, n_rs2,
                 exp_rd(rs1_addr, 0), exp_rd(rs2_addr, 0));
      end
      nvec++;
      if (b_bz1 !== exp_bz(rs1_addr, 1) || b_bz2 !== exp_bz(rs2_addr, 1)
          || n_bz1 !== exp_bz(rs1_addr, 0)
          || n_bz2 !== exp_bz(rs2_addr, 0)) begin
        nerr++;
        $display("FAIL rnd_busy i=%0d got %b%b%b%b want %b%b%b%b", i,
                 b_bz1, b_bz2, n_bz1, n_bz2,
                 exp_bz(rs1_addr, 1), exp_bz(rs2_addr, 1),
                 exp_bz(rs1_addr, 0), exp_bz(rs2_addr, 0));
      end
      nvec++;
      if (int'(b_cnt) != m_cnt() || int'(n_cnt) != m_cnt()) begin
        nerr++;
        $display("FAIL rnd_cnt i=%0d got %0d/%0d want %0d",
                 i, b_cnt, n_cnt, m_cnt());
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_x0();
    test_scoreboard();
    test_waw();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised integer register file with a write-back scoreboard for the STRV32I core. It generalises the 32x32 file with XLEN, register count and bypass mode. Same-cycle write-back forwarding is qualified by the write enable and never applies to x0. A per-register busy scoreboard tracks in-flight destination writes so decode can stall on RAW hazards without an external table. It sits between decode (read/issue) and write-back.

## Interface
- XLEN, 32, data width in bits
- AW, 5, register address width; register count NREGS = 2**AW
- BYPASS, 1, 1 = forward same-cycle write-back data to read ports; 0 = no forwarding
- clk_in  input  1  clock; all state updates on the rising edge
- rst_in  input  1  reset, asynchronous, active-high
- rs1_addr_in  input  AW  read port 1 address
- rs2_addr_in  input  AW  read port 2 address
- rs1_out  output  XLEN  read port 1 data (combinational)
- rs2_out  output  XLEN  read port 2 data (combinational)
- rs1_busy_out  output  1  source 1 has a pending write (combinational)
- rs2_busy_out  output  1  source 2 has a pending write (combinational)
- issue_en_in  input  1  decode issued an instruction writing issue_rd_in
- issue_rd_in  input  AW  destination of the issued instruction
- wr_en_in  input  1  write-back valid
- wr_addr_in  input  AW  write-back destination
- wr_data_in  input  XLEN  write-back data
- flush_in  input  1  pipeline flush; clears every busy bit
- busy_cnt_out  output  AW+1  number of registers currently marked busy (registered)

## Operation
- Storage: NREGS x XLEN array plus NREGS busy bits. Entry 0 reads as zero, is never written, and is never busy.
- Write: on an edge with wr_en_in=1 and wr_addr_in!=0, array[wr_addr_in] <= wr_data_in. A write to 0 is ignored.
- Read, rsN_out:
  - If rsN_addr_in==0, output 0.
  - Else if BYPASS=1 and wr_en_in=1 and wr_addr_in==rsN_addr_in, output wr_data_in.
  - Else output array[rsN_addr_in].
- Busy bit update per register r!=0 at each edge, in priority order:
  - Issue to r: set to 1. This applies even when flush_in=1, or when a write-back to r occurs in the same cycle; the new producer wins.
  - Else flush_in=1: clear to 0.
  - Else write-back to r (wr_en_in=1): clear to 0.
  - Else hold.
- Issue or write-back to r=0 has no scoreboard effect.
- Issue to an already-busy register is legal (WAW). The bit stays 1 and there is no count change.
- Write-back to a non-busy register is legal. The data is written and there is no count change.
- rsN_busy_out = busy[rsN_addr_in], except:
  - It is 0 for address 0.
  - With BYPASS=1, it is 0 when wr_en_in=1 and wr_addr_in==rsN_addr_in (data is forwarded this cycle).
  - With BYPASS=0, it remains 1 during the write-back cycle.
- busy_cnt_out tracks the popcount of the busy bits. It is updated on the same edge as the bits: next = current + (issue sets a clear bit) − (write-back clears a set bit not re-issued). On flush, next = 1 if the issue sets a bit that cycle, else 0. It never exceeds NREGS−1.

## Timing
- Reset (async assertion, values hold while rst_in=1):
  - All array entries = 0, all busy bits = 0, busy_cnt_out = 0.
  - Consequently rs1_out = rs2_out = 0 and rs1_busy_out = rs2_busy_out = 0 unless bypass forwarding is active.
  - Release is synchronous to the next edge.
- Write latency: the array is updated 1 edge after wr_en_in. With BYPASS=1 the data is visible on the read ports in the same cycle (0 latency).
- Busy latency: issue in cycle N gives rsN_busy_out=1 from cycle N+1.
- Write-back clearing:
  - BYPASS=1: write-back in cycle M clears the busy indication combinationally in cycle M.
  - BYPASS=0: the busy indication clears from cycle M+1.
- Reset mid-operation discards all pending busy state and data. No write or issue in the reset-assertion cycle takes effect.

## Test plan
- Reset then read all addresses → rs1_out=rs2_out=0, both busy=0, busy_cnt_out=0.
- Write x5=0xDEADBEEF with rs1=5 in the same cycle, BYPASS=1 → rs1_out=0xDEADBEEF that cycle and 0xDEADBEEF after the edge. Repeat with BYPASS=0 → old value (0) that cycle, new value next cycle.
- Write x0=0x12345678 with rs1=0 in the same cycle → rs1_out=0 that cycle and after; busy_cnt_out unchanged.
- Issue x3, then x7 (two cycles) → busy_cnt_out=2, rs1=3 gives busy=1. Write-back x3=0x11 → busy clears in the same cycle (BYPASS=1), busy_cnt_out=1 next cycle.
- Issue x9 and write-back x9=0x22 in the same cycle, x9 previously busy → x9 stays busy, array holds 0x22, busy_cnt_out unchanged.
- With 4 registers busy, assert flush_in together with issue x10 → next cycle busy_cnt_out=1, only x10 busy. Assert rst_in asynchronously mid-cycle → outputs go to 0 immediately.
